aes_mode_engine: RTL
====================

// Module: aes_mode_engine
// PURPOSE
//  Streaming AES-128 mode engine built around the aes_encryptor_top core (one block in flight).
//  Adds ECB/CBC/CTR-encrypt modes, IV/counter chaining, valid/ready streaming with one-block output buffering, and message framing.
//  Sits between a host DMA/stream and the core; CTR also serves as decrypt.
// PARAMETERS
//  CTR_WIDTH   32  low counter bits incremented per block (1..128); upper 128-CTR_WIDTH bits fixed
//  DATA_W      128 block width; fixed at 128, a parameter only for package use; other values illegal
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    asynchronous active-low reset
//  cfg_load   in   1    pulse: latch cfg_mode/cfg_key/cfg_iv, open a session
//  cfg_mode   in   2    0=ECB 1=CBC 2=CTR 3=reserved
//  cfg_key    in   128  AES-128 key
//  cfg_iv     in   128  CBC IV or CTR initial counter block
//  in_valid   in   1    input block valid
//  in_ready   out  1    engine accepts input block
//  in_data    in   128  plaintext (ECB/CBC) or data to XOR (CTR)
//  in_last    in   1    final block of message
//  out_valid  out  1    output block valid
//  out_ready  in   1    sink accepts output block
//  out_data   out  128  result block
//  out_last   out  1    mirrors in_last of that block
//  busy       out  1    session open or output pending
//  cfg_err    out  1    one-cycle pulse: cfg_load rejected
// BEHAVIOUR
//  Reset: state IDLE; in_ready, out_valid, out_last, busy, cfg_err = 0; out_data, key/chain/ctr regs = 0.
//  FSM: IDLE -> READY (legal cfg_load) -> CORE (input accepted, core start pulsed 1 cycle)
//   -> READY on core valid when output slot free or freed that cycle; else HOLD.
//   HOLD -> READY when slot frees. After core valid for a block with in_last: -> IDLE instead of READY (via HOLD if needed).
//  in_ready = (state==READY). Input handshake = in_valid & in_ready; core start asserted next cycle with key_q.
//  Core input: ECB in_data; CBC in_data ^ chain_q; CTR ctr_q. Input data/last captured at handshake.
//  Core result captured on the core valid pulse (core ciphertext not relied on after that cycle).
//  Result: ECB/CBC = ct, chain_q <= ct; CTR = data_q ^ ct, ctr_q low CTR_WIDTH bits +1 mod 2^CTR_WIDTH at handshake.
//  Output slot: out_valid held with data/last stable until out_valid & out_ready; freed same cycle (slot reloadable that cycle).
//  Input may be accepted while output slot full (overlap); at most one block in core plus one in slot/HOLD.
//  cfg_load: honoured only in IDLE with out_valid=0 and mode!=3; otherwise ignored and cfg_err pulses next cycle.
//  cfg_load with mode 3 in IDLE: ignored, cfg_err pulse, stays IDLE.
//  Session close: last block enters IDLE after core done; pending output still drains; busy = (state!=IDLE)|out_valid.
//  Reset mid-block: all state cleared, in-flight block and output discarded, core reset via same rst_n.
//  Latency: input handshake to out_valid = core latency + 2 cycles when slot free.
// STRUCTURE
//  Package aes_pkg: mode enum (ECB/CBC/CTR/RSVD), FSM state enum, AES_BLOCK_W=128, FIPS-197 test vector constants.
//  One sub-module: aes_encryptor_top (existing core, start/valid pulse interface), instantiated once.
//  Counter increment as a function in aes_pkg (ctr_inc, width CTR_WIDTH).
// TESTING
//  ECB: key 000102..0F, in 00112233445566778899AABBCCDDEEFF last=1 -> out 69C4E0D86A7B0430D8CDB78070B4C55A, out_last=1, then IDLE.
//  CBC IV=0, 2 blocks: in1 as above -> 69C4..C55A; in2=69C4E0D86A7B0430D8CDB78070B4C55A -> AES_k(0) per C model.
//  CTR IV=00112233445566778899AABBCCDDEEFF, in_data=0 -> out 69C4..C55A; CTR decrypt round-trip of 4 blocks matches.
//  CTR wrap: IV low 32 bits FFFFFFFF, 2 blocks -> 2nd core input low 32 bits 0, upper 96 bits unchanged.
//  Backpressure: out_ready=0 for 50 cycles over 3 blocks -> HOLD entered, data stable, no loss/dup, order kept.
//  Errors/reset: cfg_load mid-session or mode=3 -> cfg_err 1-cycle pulse, config unchanged; rst_n low in CORE -> outputs reset values.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and AES/counter helper functions
// Mode and FSM encodings, FIPS-197 reference vectors, GF(2^8) round primitives.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam logic [3:0] AES_ROUNDS = 4'd10;
  // Edges from the one that samples core start to the one that raises core valid.
  localparam int CORE_LATENCY = 10;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'd0,
    MODE_CBC  = 2'd1,
    MODE_CTR  = 2'd2,
    MODE_RSVD = 2'd3
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_CORE  = 2'd2,
    ST_HOLD  = 2'd3
  } eng_state_e;

  localparam logic [127:0] FIPS_KEY     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_CT_ZERO = 128'hc6a13b37878f5b826f4f8162a1c8d879;

  // Increment only the low 'width' bits; the upper bits of the counter block never carry.
  function automatic logic [127:0] ctr_inc(input logic [127:0] ctr, input int unsigned width);
    logic [127:0] mask;
    mask = (width >= 128) ? '1 : ((128'd1 << width) - 128'd1);
    return (ctr & ~mask) | ((ctr + 128'd1) & mask);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: a^254 is the field inverse, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte k of the block is s[127-8k -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_encryptor_top.sv
// rtl/aes_encryptor_top.sv - iterative AES-128 encryptor, one round per clock
// start loads key/plaintext; valid pulses one cycle with ct once round 10 completes.
module aes_encryptor_top
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic [AES_BLOCK_W-1:0] block_in,
  output logic                   valid,
  output logic [AES_BLOCK_W-1:0] ct
);

  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] rk_nxt, sr;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         run_q, run_d;
  logic         valid_q, valid_d;

  always_comb begin
    st_d    = st_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    run_d   = run_q;
    valid_d = 1'b0;
    rk_nxt  = key_expand(rk_q, rcon_q);
    sr      = shift_rows(sub_bytes(st_q));
    if (start) begin
      st_d    = block_in ^ key;
      rk_d    = key;
      rcon_d  = 8'h01;
      round_d = 4'd1;
      run_d   = 1'b1;
    end else if (run_q) begin
      rk_d    = rk_nxt;
      rcon_d  = xtime(rcon_q);
      round_d = round_q + 4'd1;
      // Final round skips MixColumns.
      if (round_q == AES_ROUNDS) begin
        st_d    = sr ^ rk_nxt;
        run_d   = 1'b0;
        valid_d = 1'b1;
      end else begin
        st_d = mix_columns(sr) ^ rk_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign ct    = st_q;

endmodule

// File: rtl/aes_mode_engine.sv
// rtl/aes_mode_engine.sv - streaming ECB/CBC/CTR wrapper around the AES-128 core
// One block in the core plus one in the output slot or hold buffer; framed by in_last/out_last.
module aes_mode_engine
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int DATA_W    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic [DATA_W-1:0] cfg_iv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              cfg_err
);

  eng_state_e   state_q, state_d;
  aes_mode_e    mode_q, mode_d;
  logic [127:0] key_q, key_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] data_q, data_d;
  logic         last_q, last_d;
  logic [127:0] core_in_q, core_in_d;
  logic         start_q, start_d;
  logic [127:0] res_q, res_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_last_q, out_last_d;
  logic         cfg_err_q, cfg_err_d;

  logic         core_valid;
  logic [127:0] core_ct;
  logic [127:0] core_res;
  logic         slot_free;

  aes_encryptor_top u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_q),
    .key      (key_q),
    .block_in (core_in_q),
    .valid    (core_valid),
    .ct       (core_ct)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    key_d       = key_q;
    chain_d     = chain_q;
    ctr_d       = ctr_q;
    data_d      = data_q;
    last_d      = last_q;
    core_in_d   = core_in_q;
    start_d     = 1'b0;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cfg_err_d   = 1'b0;
    core_res    = (mode_q == MODE_CTR) ? (data_q ^ core_ct) : core_ct;
    // A slot being drained this cycle can be refilled in the same cycle.
    slot_free   = !out_valid_q || out_ready;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (cfg_load) begin
      if (state_q == ST_IDLE && !out_valid_q && cfg_mode != MODE_RSVD) begin
        mode_d  = aes_mode_e'(cfg_mode);
        key_d   = cfg_key;
        chain_d = cfg_iv;
        ctr_d   = cfg_iv;
        state_d = ST_READY;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_READY: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          start_d = 1'b1;
          state_d = ST_CORE;
          case (mode_q)
            MODE_CBC: core_in_d = in_data ^ chain_q;
            MODE_CTR: begin
              core_in_d = ctr_q;
              ctr_d     = ctr_inc(ctr_q, CTR_WIDTH);
            end
            default:  core_in_d = in_data;
          endcase
        end
      end
      ST_CORE: begin
        if (core_valid) begin
          if (mode_q != MODE_CTR) chain_d = core_ct;
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = core_res;
            out_last_d  = last_q;
            state_d     = last_q ? ST_IDLE : ST_READY;
          end else begin
            res_d   = core_res;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = res_q;
          out_last_d  = last_q;
          state_d     = last_q ? ST_IDLE : ST_READY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ECB;
      key_q       <= '0;
      chain_q     <= '0;
      ctr_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      core_in_q   <= '0;
      start_q     <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      chain_q     <= chain_d;
      ctr_q       <= ctr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      core_in_q   <= core_in_d;
      start_q     <= start_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = (state_q == ST_READY);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule
